hilo_muldiv_unit: RTL
=====================

# hilo_muldiv_unit

Iterative multiply/divide unit for the EX stage. It owns the HI/LO register pair, runs MULTU/DIVU over DATA_WIDTH cycles, and applies MTHI/MTLO in a single cycle. It drives `busy` to the hazard logic so that MFHI/MFLO and back-to-back mul/div stall. `rd_data` feeds the data_d leg of the 4-way writeback-select mux.

## Interface
- `DATA_WIDTH`, default 32: operand, HI and LO width; also the iteration count.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; sampled on the rising edge.
- `op`  in  2  operation: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `is_signed`  in  1  signed variant of MULT/DIV. Ignored unless MULDIV_SIGNED_EN is defined.
- `rs_data`  in  DATA_WIDTH  multiplicand, dividend, or MTHI/MTLO source.
- `rt_data`  in  DATA_WIDTH  multiplier or divisor.
- `flush`  in  1  abort the in-flight MULT/DIV.
- `rd_sel`  in  1  read select: 0 = LO, 1 = HI.
- `rd_data`  out  DATA_WIDTH  combinational read of LO or HI, per `rd_sel`.
- `busy`  out  1  high while an iteration is in progress.

## Operation
- States are IDLE, MUL and DIV. Reset forces IDLE, HI=0, LO=0, busy=0 and count=0, asynchronously, including mid-operation.
- **Accept rule:** `start` is accepted only in IDLE. `start` while busy is ignored; the pipeline is responsible for stalling.
- **MTHI/MTLO:** on the accepting edge, HI (or LO) is loaded with rs_data. The state stays IDLE and busy stays 0.
- **MULT:** latch rs and rt, clear the 2×DATA_WIDTH accumulator, enter MUL.
  - Each cycle performs one shift-add step on the LSB of the multiplier.
  - After DATA_WIDTH steps: {HI,LO} = product, return to IDLE.
- **DIV:** restoring division, one quotient bit per cycle, then return to IDLE.
  - Result: LO = quotient, HI = remainder.
- **Divisor zero:** HI = rs_data and LO = all ones, in both signed and unsigned modes. The sign fixup is bypassed.
- **flush while busy:** the next state is IDLE and busy drops on that edge. HI/LO keep their pre-operation values.
- **flush with start on the same edge in IDLE:** flush wins and nothing is accepted.
- **Count and arithmetic:** the iteration counter is $clog2(DATA_WIDTH)+1 bits wide. All arithmetic is modulo 2^DATA_WIDTH per half. HI/LO are written only at completion, never with partial results.
- **rd_data while busy:** returns the old HI/LO value. This is legal, but the consumer must stall on busy.

## Timing
- The accepting edge is E0. busy=1 from E0 through E(DATA_WIDTH-1).
- HI/LO are updated and busy falls at E(DATA_WIDTH), i.e. 32 cycles for the default width.
- A new `start` is accepted at E(DATA_WIDTH), the same edge on which busy falls. The earliest next operation therefore begins with no bubble.
- MTHI/MTLO have 1-edge latency. rd_data reflects the new value in the following cycle.
- rd_data has zero-cycle latency from HI/LO and rd_sel.

## Configuration
- `MULDIV_SIGNED_EN` defined: when is_signed=1, MULT/DIV take operand magnitudes at E0 and apply the sign fixup in the completion cycle, so latency is unchanged.
  - Product sign = rs[MSB] ^ rt[MSB].
  - Quotient sign = rs[MSB] ^ rt[MSB].
  - Remainder sign = sign of the dividend.
- Not defined: is_signed is ignored, all MULT/DIV are unsigned, and the sign logic is absent.

## Structure
- Package `muldiv_pkg`:
  - op encodings OP_MULT, OP_DIV, OP_MTHI, OP_MTLO;
  - state enum IDLE, MUL, DIV.
- Sub-module `div_step`: purely combinational restoring step. Inputs are partial remainder, divisor and the next dividend bit; outputs are the new remainder and the quotient bit. It is instantiated once.

## Test plan
- **Reset:** assert rst_n=0 mid-MULT at cycle 10 → busy=0, HI=LO=0 immediately. After release, start MTLO rs=5 → LO=5 next cycle.
- **MULTU:** rs=0xFFFFFFFF, rt=0xFFFFFFFF → busy for exactly 32 cycles, then HI=0xFFFFFFFE and LO=0x00000001.
- **DIVU:** rs=100, rt=7 → LO=14, HI=2 at E32. Divisor zero with rs=0x1234 → HI=0x1234, LO=0xFFFFFFFF.
- **Busy and flush:** start DIV while busy → ignored, result unaffected. Flush at cycle 16 → busy=0 and HI/LO unchanged. Back-to-back start at E32 → accepted.
- **Signed (MULDIV_SIGNED_EN):**
  - MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV −7/2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - With the macro undefined, DIV rs=0xFFFFFFF9 ÷ 2 gives LO=0x7FFFFFFC.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } state_t;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/readback bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic                  flush;
    logic                  rd_sel;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        output start, op, is_signed, rs_data, rt_data, flush, rd_sel,
        input  rd_data, busy
    );

    modport slave (
        input  start, op, is_signed, rs_data, rt_data, flush, rd_sel,
        output rd_data, busy
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // rem_in < divisor holds between steps, so diff's MSB is a clean borrow flag
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DATA_WIDTH];
    assign rem_out = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/DIV owning HI/LO, with single-cycle MTHI/MTLO and a busy flag for hazard stalls.
// Define MULDIV_SIGNED_EN to honour is_signed (magnitude iteration, sign fixup on completion).
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    hilo_muldiv_unit_if.slave bus
);
    // state | meaning
    // IDLE  | no iteration running; start (MULT/DIV/MTHI/MTLO) may be accepted
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    state_t          state, state_nx;
    op_t             op_in;
    logic            accept, finish, last_step;
    logic            acc_mul, acc_div;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  acc, acc_step, mul_next, div_next;
    logic [W:0]      mul_sum;
    logic [W-1:0]    mcand, divisor, rs_orig, hi, lo;
    logic [W-1:0]    rs_mag, rt_mag, rem_nx, res_hi, res_lo;
    logic            div_zero, q_bit;

    assign op_in   = op_t'(bus.op);
    assign acc_mul = accept && (op_in == OP_MULT);
    assign acc_div = accept && (op_in == OP_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        finish    = 1'b0;
        last_step = (count == CW'(1));
        case (state)
            IDLE: accept = bus.start & ~bus.flush;
            MUL, DIV: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (last_step) begin
                    state_nx = IDLE;
                    finish   = 1'b1;
                    accept   = bus.start;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (accept) begin
            if (op_in == OP_MULT)     state_nx = MUL;
            else if (op_in == OP_DIV) state_nx = DIV;
        end
    end

`ifdef MULDIV_SIGNED_EN
    logic rs_neg, rt_neg, neg_res, neg_rem;

    assign rs_neg = bus.is_signed & bus.rs_data[W-1];
    assign rt_neg = bus.is_signed & bus.rt_data[W-1];
    assign rs_mag = rs_neg ? -bus.rs_data : bus.rs_data;
    assign rt_mag = rt_neg ? -bus.rt_data : bus.rt_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (acc_mul || acc_div) begin
            neg_res <= rs_neg ^ rt_neg;
            neg_rem <= rs_neg;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = bus.is_signed;
    assign rs_mag           = bus.rs_data;
    assign rt_mag           = bus.rt_data;
`endif

    // multiplier sits in acc's low half and is shifted out as product bits shift in
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mcand : {W{1'b0}})};
    assign mul_next = {mul_sum, acc[W-1:1]};

    div_step #(.DATA_WIDTH(W)) u_div_step (
        .rem_in  (acc[2*W-1:W]),
        .divisor (divisor),
        .bit_in  (acc[W-1]),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    assign div_next = {rem_nx, acc[W-2:0], q_bit};
    assign acc_step = (state == MUL) ? mul_next : div_next;

    always_comb begin
        res_hi = acc_step[2*W-1:W];
        res_lo = acc_step[W-1:0];
        if (state == DIV && div_zero) begin
            res_hi = rs_orig;
            res_lo = {W{1'b1}};
        end
`ifdef MULDIV_SIGNED_EN
        else if (state == MUL && neg_res) begin
            {res_hi, res_lo} = -acc_step;
        end else if (state == DIV) begin
            if (neg_res) res_lo = -acc_step[W-1:0];
            if (neg_rem) res_hi = -acc_step[2*W-1:W];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            divisor  <= '0;
            rs_orig  <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (acc_mul) begin
                acc   <= {{W{1'b0}}, rt_mag};
                mcand <= rs_mag;
                count <= CW'(W);
            end else if (acc_div) begin
                acc      <= {{W{1'b0}}, rs_mag};
                divisor  <= rt_mag;
                rs_orig  <= bus.rs_data;
                div_zero <= (bus.rt_data == '0);
                count    <= CW'(W);
            end else if (state != IDLE) begin
                acc   <= acc_step;
                count <= bus.flush ? '0 : count - CW'(1);
            end
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            // an MTHI/MTLO issued on a completion edge is younger, so it overrides
            if (accept && op_in == OP_MTHI) hi <= bus.rs_data;
            if (accept && op_in == OP_MTLO) lo <= bus.rs_data;
        end
    end

    assign bus.rd_data = bus.rd_sel ? hi : lo;
    assign bus.busy    = (state != IDLE);
endmodule
